// File: rtl/mem_block_bridge_if.sv
// Narrow request/acknowledge main-memory bus used by mem_block_bridge.
// One beat per wreq/wack handshake; wack sampled at posedge while wreq=1.
interface mem_block_bridge_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WDATA_WIDTH = 32
);
    logic                   wreq;
    logic                   wwe;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [WDATA_WIDTH-1:0] wdata_o;
    logic [WDATA_WIDTH-1:0] wdata_i;
    logic                   wack;

    modport master (
        output wreq, wwe, waddr, wdata_o,
        input  wdata_i, wack
    );

    modport slave (
        input  wreq, wwe, waddr, wdata_o,
        output wdata_i, wack
    );
endinterface

// File: rtl/mem_block_bridge.sv
// Cache block port to word-burst memory bridge, plus stdout/exit singles.
// Optional statistics counters enabled by MEM_BLOCK_BRIDGE_STATS_EN.
module mem_block_bridge #(
    parameter int MDATA_WIDTH = 256,
    parameter int WDATA_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] STDOUT_ADDR = 32'hf000_0000,
    parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR   = 32'hff00_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mreq,
    input  logic                   mwrite,
    input  logic [ADDR_WIDTH-1:0]  maddr,
    inout  wire  [MDATA_WIDTH-1:0] mdata,
    output logic                   ackm_n,
    mem_block_bridge_if.master     mem,
    output logic                   exit_seen,
    output logic [31:0]            stat_rd,
    output logic [31:0]            stat_wr,
    output logic [31:0]            stat_stall
);
    localparam int BEATS = MDATA_WIDTH / WDATA_WIDTH;
    localparam int BW    = $clog2(BEATS);
    localparam int OFFW  = $clog2(MDATA_WIDTH / 8);
    localparam int REST  = MDATA_WIDTH - WDATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFFW) - 1);
    localparam logic [ADDR_WIDTH-1:0] WSTEP    = ADDR_WIDTH'(WDATA_WIDTH / 8);
    localparam logic [BW-1:0]         LAST     = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, WBURST, RBURST, SINGLE, ACK
    } state_t;

    state_t                 state_q;
    logic                   wreq_q;
    logic                   wwe_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [WDATA_WIDTH-1:0] wdata_q;
    logic [MDATA_WIDTH-1:0] blk_q;
    logic [BW-1:0]          beat_q;
    logic                   rd_q;
    logic                   exit_q;
    logic                   exit_seen_q;
    logic                   is_single;

    // Write block shifts out of the top of blk_q; read words shift in at the bottom,
    // so after the last beat beat 0 sits in the MSB word.
    assign is_single = mwrite && (maddr == STDOUT_ADDR || maddr == EXIT_ADDR);

    assign mem.wreq    = wreq_q;
    assign mem.wwe     = wwe_q;
    assign mem.waddr   = waddr_q;
    assign mem.wdata_o = wdata_q;
    assign exit_seen   = exit_seen_q;
    assign ackm_n      = (state_q != ACK);
    assign mdata       = (state_q == ACK && rd_q) ? blk_q : 'z;

    // Transfer sequencer with registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wreq_q      <= 1'b0;
            wwe_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            blk_q       <= '0;
            beat_q      <= '0;
            rd_q        <= 1'b0;
            exit_q      <= 1'b0;
            exit_seen_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mreq) begin
                        rd_q   <= !mwrite;
                        exit_q <= mwrite && (maddr == EXIT_ADDR);
                        beat_q <= '0;
                        wreq_q <= 1'b1;
                        wwe_q  <= mwrite;
                        if (mwrite) begin
                            blk_q <= mdata;
                        end
                        if (is_single) begin
                            state_q <= SINGLE;
                            waddr_q <= maddr;
                            wdata_q <= mdata[WDATA_WIDTH-1:0];
                        end else begin
                            state_q <= mwrite ? WBURST : RBURST;
                            waddr_q <= maddr & ~OFF_MASK;
                            wdata_q <= mwrite ? mdata[MDATA_WIDTH-1 -: WDATA_WIDTH] : '0;
                        end
                    end
                end
                WBURST, RBURST: begin
                    if (mem.wack) begin
                        if (state_q == RBURST) begin
                            blk_q   <= {blk_q[REST-1:0], mem.wdata_i};
                            wdata_q <= '0;
                        end else begin
                            blk_q   <= blk_q << WDATA_WIDTH;
                            wdata_q <= blk_q[REST-1 -: WDATA_WIDTH];
                        end
                        if (beat_q == LAST) begin
                            wreq_q  <= 1'b0;
                            wwe_q   <= 1'b0;
                            state_q <= ACK;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            waddr_q <= waddr_q + WSTEP;
                        end
                    end
                end
                SINGLE: begin
                    if (mem.wack) begin
                        wreq_q  <= 1'b0;
                        wwe_q   <= 1'b0;
                        state_q <= ACK;
                        if (exit_q) begin
                            exit_seen_q <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_BLOCK_BRIDGE_STATS_EN
    logic burst_done;
    logic single_done;

    assign burst_done  = mem.wack && beat_q == LAST
                      && (state_q == WBURST || state_q == RBURST);
    assign single_done = mem.wack && state_q == SINGLE;

    // Completion and stall counters; free-running, wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_stall <= '0;
        end else begin
            if (burst_done && state_q == RBURST) begin
                stat_rd <= stat_rd + 32'd1;
            end
            if ((burst_done && state_q == WBURST) || single_done) begin
                stat_wr <= stat_wr + 32'd1;
            end
            if (wreq_q && !mem.wack) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    assign stat_rd    = '0;
    assign stat_wr    = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_mem_block_bridge.sv
// Directed scoreboard bench for mem_block_bridge.
// Expected beats are queued per request and popped as the memory acks them.
module tb_mem_block_bridge;
    localparam logic [31:0] STDOUT_A = 32'hf000_0000;
    localparam logic [31:0] EXIT_A   = 32'hff00_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         mreq;
    logic         mwrite;
    logic [31:0]  maddr;
    wire  [255:0] mdata;
    logic         ackm_n;
    logic         exit_seen;
    logic [31:0]  stat_rd;
    logic [31:0]  stat_wr;
    logic [31:0]  stat_stall;

    logic         mdrv;
    logic [255:0] mval;

    int           vectors;
    int           miscompares;
    beat_t        exp_q[$];
    logic [255:0] exp_blk;
    logic         cur_we;
    int           cur_beats;

    mem_block_bridge_if #(.ADDR_WIDTH(32), .WDATA_WIDTH(32)) bus ();

    assign mdata = mdrv ? mval : 'z;

    mem_block_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .mreq       (mreq),
        .mwrite     (mwrite),
        .maddr      (maddr),
        .mdata      (mdata),
        .ackm_n     (ackm_n),
        .mem        (bus.master),
        .exit_seen  (exit_seen),
        .stat_rd    (stat_rd),
        .stat_wr    (stat_wr),
        .stat_stall (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hc3a5, a[31:16] + 16'h0101};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a cache request at a negedge and queue the beats it must produce.
    task automatic start_req(input logic we, input logic [31:0] addr,
                             input logic [255:0] data);
        logic [31:0] base;
        beat_t       b;
        mreq    = 1'b1;
        mwrite  = we;
        maddr   = addr;
        mdrv    = we;
        mval    = data;
        cur_we  = we;
        exp_blk = '0;
        exp_q.delete();
        if (we && (addr == STDOUT_A || addr == EXIT_A)) begin
            b.addr = addr;
            b.we   = 1'b1;
            b.data = data[31:0];
            exp_q.push_back(b);
            cur_beats = 1;
        end else begin
            base = addr & 32'hffff_ffe0;
            for (int k = 0; k < 8; k++) begin
                b.addr = base + 32'(4 * k);
                b.we   = we;
                b.data = we ? data[255-32*k -: 32] : memfn(b.addr);
                exp_q.push_back(b);
                exp_blk[255-32*k -: 32] = memfn(b.addr);
            end
            cur_beats = 8;
        end
    endtask

    // Serve the memory side until the ack pulse (or until `abort` beats acked).
    task automatic run_txn(input int stall, input int lead, input int abort);
        int    idx;
        int    waits;
        int    nb;
        bit    done;
        beat_t f;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            check("ack_one_cycle", ackm_n, 1'b1);
        end
        @(negedge clk);
        mreq   = 1'b0;
        maddr  = 32'h0bad_0000;
        mwrite = ~mwrite;
        if (mdrv) mval = ~mval;
        idx   = 1;
        waits = stall;
        nb    = 0;
        done  = 0;
        while (!done && idx < 200) begin
            if (abort != 0 && nb == abort) begin
                done = 1;
            end else if (ackm_n === 1'b0) begin
                check("ack_cycle", idx, cur_beats * (stall + 1) + 1);
                check("beats_left", exp_q.size(), 0);
                check("mdata_at_ack", mdata, cur_we ? mval : exp_blk);
                bus.wack = 1'b0;
                done = 1;
            end else begin
                if (bus.wreq === 1'b1 && exp_q.size() > 0) begin
                    f = exp_q[0];
                    check("waddr", bus.waddr, f.addr);
                    check("wwe", bus.wwe, f.we);
                    if (f.we) check("wdata_o", bus.wdata_o, f.data);
                    if (waits == 0) begin
                        bus.wack    = 1'b1;
                        bus.wdata_i = memfn(bus.waddr);
                        void'(exp_q.pop_front());
                        nb++;
                        waits = stall;
                    end else begin
                        bus.wack = 1'b0;
                        waits--;
                    end
                end else begin
                    bus.wack = 1'b0;
                end
                @(negedge clk);
                idx++;
            end
        end
        if (!done) check("txn_timeout", idx, 0);
    endtask

    initial begin
        logic [255:0] pat;
        logic [31:0]  s_rd;
        logic [31:0]  s_wr;
        logic [31:0]  s_st;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        mreq        = 1'b0;
        mwrite      = 1'b0;
        maddr       = '0;
        mdrv        = 1'b0;
        mval        = '0;
        bus.wack    = 1'b0;
        bus.wdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_wreq", bus.wreq, 1'b0);
        check("rst_wwe", bus.wwe, 1'b0);
        check("rst_waddr", bus.waddr, 32'h0);
        check("rst_wdata_o", bus.wdata_o, 32'h0);
        check("rst_ackm_n", ackm_n, 1'b1);
        check("rst_exit_seen", exit_seen, 1'b0);
        check("rst_stat_rd", stat_rd, 32'h0);
        check("rst_stat_stall", stat_stall, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Read refill, zero-wait memory.
        start_req(1'b0, 32'h0000_1234, '0);
        run_txn(0, 0, 0);
        @(negedge clk);
        check("ack_one_cycle", ackm_n, 1'b1);

        // Writeback then refill raised in the ACK cycle.
        for (int i = 0; i < 32; i++) pat[255-8*i -: 8] = 8'(i);
        start_req(1'b1, 32'h0000_2000, pat);
        run_txn(0, 0, 0);
        start_req(1'b0, 32'h0000_4000, '0);
        run_txn(0, 1, 0);
        @(negedge clk);
        check("ack_one_cycle", ackm_n, 1'b1);

        // Read with three stall cycles per beat.
        s_rd = stat_rd;
        s_wr = stat_wr;
        s_st = stat_stall;
        start_req(1'b0, 32'h0000_8040, '0);
        run_txn(3, 0, 0);
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
        check("stat_stall_delta", stat_stall - s_st, 32'd24);
        check("stat_rd_delta", stat_rd - s_rd, 32'd1);
        check("stat_wr_delta", stat_wr - s_wr, 32'd0);
`else
        check("stat_stall_off", stat_stall, 32'd0);
        check("stat_rd_off", stat_rd, 32'd0);
        check("stat_wr_off", stat_wr, 32'd0);
`endif
        @(negedge clk);

        // Stdout single write.
        start_req(1'b1, STDOUT_A, 256'h41);
        run_txn(0, 0, 0);
        check("stdout_exit_seen", exit_seen, 1'b0);
        @(negedge clk);

        // Exit single write sets the sticky flag.
        s_wr = stat_wr;
        start_req(1'b1, EXIT_A, {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, 32'h0000_0001});
        run_txn(1, 0, 0);
        check("exit_seen_set", exit_seen, 1'b1);
`ifdef MEM_BLOCK_BRIDGE_STATS_EN
        check("stat_wr_single", stat_wr - s_wr, 32'd1);
`endif
        @(negedge clk);

        // Stalled write burst; exit flag must hold.
        start_req(1'b1, 32'h0000_3008, {$urandom, $urandom, $urandom, $urandom,
                                        $urandom, $urandom, $urandom, $urandom});
        run_txn(1, 0, 0);
        check("exit_seen_held", exit_seen, 1'b1);
        @(negedge clk);

        // Reset during beat 4 of a read, then a fresh request.
        start_req(1'b0, 32'h0000_6010, '0);
        run_txn(0, 0, 4);
        check("abort_beat4_addr", bus.waddr, 32'h0000_6010);
        bus.wack = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_wreq", bus.wreq, 1'b0);
        check("abort_ackm_n", ackm_n, 1'b1);
        check("abort_exit_clr", exit_seen, 1'b0);
        mdrv = 1'b1;
        mval = {8{32'h5a5a_c3c3}};
        #1;
        check("abort_mdata_free", mdata, {8{32'h5a5a_c3c3}});
        @(negedge clk);
        check("abort_ack_none", ackm_n, 1'b1);
        rst  = 1'b0;
        mdrv = 1'b0;
        @(negedge clk);
        start_req(1'b0, 32'h0000_6010, '0);
        run_txn(0, 0, 0);
        @(negedge clk);
        check("ack_one_cycle", ackm_n, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
